hazard_stall_ctl: RTL and testbench
===================================

Name: hazard_stall_ctl

Overview:
- Pipeline control block that drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- It is the consumer/driver side of the ID/EX stage register's `en` interface:
  - reads the ID-stage source operands and the ID/EX destination/control fields;
  - decides each cycle whether the pipe advances, freezes, squashes or halts.
- Handles:
  - load-use RAW stalls (all other RAW cases are covered by EX/MEM and MEM/WB forwarding);
  - EX-resolved branch/jump squash;
  - data-memory busy freeze;
  - `dump`-triggered drain-and-halt.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after a `dump` enters ID/EX before halting (legal 1..7).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  3  ID-stage source register 1 number
- id_rs_vld  in  1  ID instruction reads `id_rs`
- id_rt  in  3  ID-stage source register 2 number
- id_rt_vld  in  1  ID instruction reads `id_rt`
- id_dump  in  1  ID instruction is halt/dump
- idex_dst_reg_num  in  3  destination register held in ID/EX
- idex_RegWriteEN  in  1  ID/EX instruction writes the register file
- idex_MemEn  in  1  ID/EX memory enable
- idex_MemWr  in  1  ID/EX memory write
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- mem_stall  in  1  data memory busy; whole pipe must freeze
- pc_en  out  1  PC register enable
- ifid_en  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_en  out  1  ID/EX enable
- idex_bubble  out  1  ID/EX loads all-zero control (NOP)
- exmem_en  out  1  EX/MEM and MEM/WB enable
- halted  out  1  pipeline halted
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- State register: RUN, DRAIN, HALT. Drain counter `dcnt` is 3 bits. Both are registered.
- Reset (rst=1 at a clock edge): state=RUN, dcnt=0, stall_count=0.
  - While rst=1, outputs are forced to: all enables 1, `ifid_flush`=0, `idex_bubble`=0, `halted`=0.
- Load-use hazard, `lu`, is true when all of the following hold:
  - idex_MemEn & ~idex_MemWr & idex_RegWriteEN; and
  - (id_rs_vld & id_rs==idex_dst_reg_num) | (id_rt_vld & id_rt==idex_dst_reg_num).
- Outputs are combinational from state plus inputs. Default is all enables 1, flush/bubble 0.
- RUN, priority high to low:
  1. mem_stall=1: all enables 0, no flush/bubble; state holds. Overrides `lu`, `ex_redirect` and `id_dump` that cycle; they are re-evaluated next cycle.
  2. ex_redirect=1: pc_en=1 (PC loads target), ifid_flush=1, idex_bubble=1. Wrong-path `lu` and `id_dump` are ignored.
  3. lu=1: pc_en=0, ifid_en=0, idex_en=1 with idex_bubble=1.
     - Exactly one bubble; the hazard clears next cycle as the load advances.
  4. id_dump=1: pc_en=0, ifid_en=0, idex_en=1 (dump enters ID/EX).
     - Next state DRAIN, dcnt=DRAIN_CYCLES.
  5. Otherwise: all enables 1.
- DRAIN:
  - Outputs: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=~mem_stall.
  - dcnt decrements only on cycles with mem_stall=0.
  - When dcnt==1 and mem_stall=0, next state is HALT.
  - ex_redirect and id_dump are ignored; no branch can be older than the dump in EX.
- HALT: all enables 0, halted=1. Stays in HALT until rst.
- stall_count increments by 1 on every RUN cycle with mem_stall=1 or lu=1 (after priority, i.e. only when a stall is actually issued).
  - Saturates at all-ones.
  - Does not count in DRAIN or HALT.
- Simultaneous events:
  - `lu` and `id_dump` on the same instruction: the stall is taken first; the dump is accepted the following cycle.
  - `ex_redirect` and `mem_stall` together: freeze wins; the redirect must be held by EX and acted on after the freeze.

Test Plan:
- Load-use stall: ID/EX holds LD r3 (MemEn=1, MemWr=0, RegWriteEN=1, dst=3); ID reads rs=3 (vld=1).
  - Cycle N: pc_en=0, ifid_en=0, idex_bubble=1.
  - Cycle N+1 (ID/EX now a bubble): all enables 1.
  - stall_count=1.
- No false stall: store in ID/EX (MemWr=1) with a matching dst; or a load whose dst=3 while ID reads rt=3 with rt_vld=0 → no stall, stall_count stays 0.
- Redirect beats load-use: ex_redirect=1 with lu=1 → ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1; stall_count unchanged.
- Memory freeze: mem_stall held 4 cycles, asserted together with lu=1 and ex_redirect=1.
  - All enables 0 for 4 cycles; stall_count +4.
  - After release, the redirect is applied: flush=1, bubble=1.
- Dump drain with DRAIN_CYCLES=3: id_dump=1 at cycle N.
  - Cycles N+1..N+3: DRAIN with idex_bubble=1.
  - With one mem_stall cycle inserted inside DRAIN: HALT is reached one cycle later.
  - From then on: halted=1, all enables 0.
- Reset mid-operation: assert rst while in DRAIN (dcnt=2) and again with stall_count=16'hFFFF.
  - Next cycle: RUN, halted=0, stall_count=0, enables 1.
  - A separate saturation run holds stall_count at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_ctl.sv
// ============================================================================
// Module      : hazard_stall_ctl
// Description : Pipeline enable/flush/bubble control for load-use stalls,
//               EX redirects, data-memory freezes and dump drain-and-halt.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic             id_rs_vld,
  input  logic [2:0]       id_rt,
  input  logic             id_rt_vld,
  input  logic             id_dump,
  input  logic [2:0]       idex_dst_reg_num,
  input  logic             idex_RegWriteEN,
  input  logic             idex_MemEn,
  input  logic             idex_MemWr,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [2:0] c_DRAIN_INIT = 3'(DRAIN_CYCLES);

  logic [1:0]       r_state;
  logic [2:0]       r_dcnt;
  logic [CNT_W-1:0] r_stall_count;
  logic [1:0]       w_state_nxt;
  logic [2:0]       w_dcnt_nxt;
  logic             w_lu;
  logic             w_stall_issued;

  // Only a load still in ID/EX cannot be covered by forwarding.
  assign w_lu = idex_MemEn & ~idex_MemWr & idex_RegWriteEN &
                ((id_rs_vld & (id_rs == idex_dst_reg_num)) |
                 (id_rt_vld & (id_rt == idex_dst_reg_num)));

  assign w_stall_issued = (r_state == S_RUN) &
                          (mem_stall | (~ex_redirect & w_lu));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_dcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      S_RUN: begin
        if (!mem_stall && !ex_redirect && !w_lu && id_dump) begin
          w_state_nxt = S_DRAIN;
          w_dcnt_nxt  = c_DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (!mem_stall) begin
          w_dcnt_nxt = r_dcnt - 3'd1;
          if (r_dcnt == 3'd1) begin
            w_state_nxt = S_HALT;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_dcnt_nxt  = 3'd0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    halted      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
          end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_dump) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
          end
        end
        S_DRAIN: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          exmem_en    = ~mem_stall;
        end
        default: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          halted   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall_issued && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctl.sv
// ============================================================================
// Module      : tb_hazard_stall_ctl
// Description : Scoreboard bench for hazard_stall_ctl with a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [6:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] id_rs, id_rt, idex_dst_reg_num;
  logic id_rs_vld, id_rt_vld, id_dump, idex_RegWriteEN, idex_MemEn, idex_MemWr;
  logic ex_redirect, mem_stall;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, halted;
  logic [CNT_W-1:0] stall_count;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   drv_done = 1'b0;

  // Model state: halted flag, remaining drain cycles (0 = running), stall tally.
  bit m_halt  = 1'b0;
  int m_drain = 0;
  int m_cnt   = 0;

  hazard_stall_ctl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .id_dump(id_dump), .idex_dst_reg_num(idex_dst_reg_num),
    .idex_RegWriteEN(idex_RegWriteEN), .idex_MemEn(idex_MemEn),
    .idex_MemWr(idex_MemWr), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .halted(halted),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic clr();
    rst = 0; id_rs = 0; id_rs_vld = 0; id_rt = 0; id_rt_vld = 0; id_dump = 0;
    idex_dst_reg_num = 0; idex_RegWriteEN = 0; idex_MemEn = 0; idex_MemWr = 0;
    ex_redirect = 0; mem_stall = 0;
  endtask

  task automatic set_load(input logic [2:0] dst);
    idex_MemEn = 1; idex_MemWr = 0; idex_RegWriteEN = 1; idex_dst_reg_num = dst;
  endtask

  // Applies the current inputs for one cycle: push expectation, then advance model.
  task automatic step();
    bit lu, pc, ifd, fl, ide, bub, exm, hlt;
    exp_t e;
    lu = idex_MemEn && !idex_MemWr && idex_RegWriteEN &&
         ((id_rs_vld && id_rs == idex_dst_reg_num) ||
          (id_rt_vld && id_rt == idex_dst_reg_num));
    pc = 1; ifd = 1; fl = 0; ide = 1; bub = 0; exm = 1; hlt = 0;
    if (!rst) begin
      if (m_halt) begin
        pc = 0; ifd = 0; ide = 0; exm = 0; hlt = 1;
      end else if (m_drain > 0) begin
        pc = 0; ifd = 0; bub = 1; exm = !mem_stall;
      end else if (mem_stall) begin
        pc = 0; ifd = 0; ide = 0; exm = 0;
      end else if (ex_redirect) begin
        fl = 1; bub = 1;
      end else if (lu) begin
        pc = 0; ifd = 0; bub = 1;
      end else if (id_dump) begin
        pc = 0; ifd = 0;
      end
    end
    e.ctl = {pc, ifd, fl, ide, bub, exm, hlt};
    e.cnt = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_halt = 0; m_drain = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (m_drain > 0) begin
        if (!mem_stall) begin
          m_drain--;
          if (m_drain == 0) m_halt = 1;
        end
      end else begin
        if (mem_stall || (!ex_redirect && lu)) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        if (!mem_stall && !ex_redirect && !lu && id_dump) m_drain = DRAIN_CYCLES;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, halted};
      n_vec++;
      if (act !== e.ctl || stall_count !== e.cnt) begin
        n_err++;
        $display("FAIL vec%0d ctl{pc,ifid,flush,idex,bub,exmem,halt} got %b want %b, stall_count got %h want %h",
                 n_vec, act, e.ctl, stall_count, e.cnt);
      end
    end
  end

  initial begin
    clr();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    clr();
    step();                                   // reset state, idle run

    set_load(3); id_rs = 3; id_rs_vld = 1; step();  // load-use bubble
    clr(); step();                                   // hazard gone

    clr(); idex_MemEn = 1; idex_MemWr = 1; idex_RegWriteEN = 1; idex_dst_reg_num = 3;
    id_rs = 3; id_rs_vld = 1; step();                // store: no stall
    clr(); set_load(3); id_rt = 3; id_rt_vld = 0; step();  // unread rt: no stall

    clr(); set_load(5); id_rt = 5; id_rt_vld = 1; ex_redirect = 1; step();  // redirect wins

    mem_stall = 1; repeat (4) step();                // freeze beats lu + redirect
    mem_stall = 0; step();                           // redirect applied after freeze
    clr(); step();

    id_dump = 1; set_load(2); id_rs = 2; id_rs_vld = 1; step();  // lu before dump
    clr(); id_dump = 1; step();                      // dump accepted
    clr(); repeat (5) step();                        // drain then halt

    rst = 1; step(); clr();
    id_dump = 1; step(); clr();
    step(); mem_stall = 1; step(); mem_stall = 0;    // freeze inside drain
    repeat (4) step();

    rst = 1; step(); clr();
    id_dump = 1; step(); clr(); step();              // drain with dcnt=2
    rst = 1; step(); clr(); step();

    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 39) == 0);
      id_rs            = 3'($urandom_range(0, 3));
      id_rt            = 3'($urandom_range(0, 3));
      idex_dst_reg_num = 3'($urandom_range(0, 3));
      id_rs_vld        = 1'($urandom);
      id_rt_vld        = 1'($urandom);
      idex_MemEn       = 1'($urandom);
      idex_MemWr       = ($urandom_range(0, 3) == 0);
      idex_RegWriteEN  = ($urandom_range(0, 3) != 0);
      ex_redirect      = ($urandom_range(0, 5) == 0);
      mem_stall        = ($urandom_range(0, 4) == 0);
      id_dump          = ($urandom_range(0, 19) == 0);
      step();
    end

    clr(); rst = 1; step(); clr();
    mem_stall = 1;
    for (int i = 0; i < CNT_MAX + 4; i++) step();    // saturation
    mem_stall = 0; set_load(1); id_rs = 1; id_rs_vld = 1; step();
    clr(); step();
    rst = 1; step(); clr(); step();                  // reset from all-ones

    drv_done = 1'b1;
  end

  initial begin
    wait (drv_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_queue got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
